// File: rtl/demux_1x4_buf.sv
// demux_1x4_buf: registered 1-to-4 demultiplexer.
// One valid/ready input stream carries a 2-bit destination select with each
// word. Each word lands in one of four single-entry holding registers, and
// each register has its own valid/ready handshake toward its consumer.
// Every channel also keeps an 8-bit wrapping count of delivered words.
//
// Handshake semantics (input side and every output channel):
//   A word moves on a rising edge exactly when valid and ready are both high.
//   valid, once raised, holds until that transfer; the payload is stable
//   while valid is high and ready is low. in_ready is combinational and looks
//   only at the targeted channel. It is high when that channel is empty, or
//   when it is being drained in the same cycle.
//
// WIDTH: legal range 1..32.

module demux_1x4_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  input  logic [1:0]       cnt_sel,
  output logic [7:0]       cnt_out,
  output logic             idle
);

  // Per-channel state.
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [7:0]       cnt_q  [4];
  logic [7:0]       cnt_d  [4];

  // Per-cycle events.
  logic [3:0] sel_oh;
  logic       accept;
  logic [3:0] load;
  logic [3:0] drain;

  // One-hot decode of the destination select.
  always_comb begin
    sel_oh = 4'b0001 << in_sel;
  end

  // Input ready depends only on the targeted channel. A full channel that is
  // not draining blocks the producer, even when other channels are free.
  always_comb begin
    in_ready = rst_n & (~valid_q[in_sel] | out_ready[in_sel]);
  end

  // Load and drain events for this edge.
  always_comb begin
    accept = in_valid & in_ready;
    load   = accept ? sel_oh : 4'b0000;
    drain  = valid_q & out_ready;
  end

  // Next state. A drain clears valid unless the same channel reloads on this
  // edge, which gives one word per cycle per channel. A drain on an empty
  // channel cannot happen because drain is gated by valid_q.
  always_comb begin
    valid_d = (valid_q & ~drain) | load;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = load[i] ? in_data : data_q[i];
      cnt_d[i]  = cnt_q[i] + {7'd0, drain[i]};
    end
  end

  // State registers with synchronous active-low reset. Reset discards any
  // buffered words without a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= 8'd0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Output views of the registered state.
  always_comb begin
    out_valid = valid_q;
    out_data0 = data_q[0];
    out_data1 = data_q[1];
    out_data2 = data_q[2];
    out_data3 = data_q[3];
    cnt_out   = cnt_q[cnt_sel];
    idle      = ~|valid_q;
  end

endmodule
